// File: rtl/fft_pkg.sv
// fft_pkg: shared types for the fft frame sequencer.
//   fpt       signed 16-bit sample word, 2.14 fixed point (FPT_ONE = 1.0)
//   state_t   sequencer FSM state encoding
//   bitrev()  reverses the low n bits of a word (n <= 32)
package fft_pkg;

  typedef logic signed [15:0] fpt;

  localparam fpt FPT_ONE = 16'sh4000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_STREAM = ST_STREAM,
    S_GAP    = ST_GAP,
    S_DRAIN  = ST_DRAIN,
    S_DONE   = ST_DONE
  } state_t;

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) r[i[4:0]] = v[5'(n - 1 - i)];
    return r;
  endfunction

endpackage

// File: rtl/fft_seq_ram.sv
// fft_seq_ram: simple dual-port RAM, one write port, one registered read port.
//   clk_i    clock            rst_n_i  sync reset (clears only the read register)
//   we_i     write enable     waddr_i / wdata_i  write address / data
//   re_i     read enable      raddr_i  read address
//   rdata_o  read data, valid the cycle after re_i; holds when re_i is low
module fft_seq_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: multi-frame feed/capture engine for the R2SDF fft core.
// Streams FRAMES frames of 2^N samples from an input buffer into the fft
// (start_ip marks each frame head, GAP idle cycles between frames), captures
// two-word op_raw beats into a result buffer, and exposes a host read port.
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_we/addr/data    input-buffer write (ignored while busy)
//   go                  start pulse (ignored while busy)
//   busy, done, err     status; done/err sticky until next go
//   start_ip, ip, ip_valid   sample stream to the fft
//   op_ready, op_raw    result beats from the fft
//   rd_addr, rd_data    result read, one cycle latency
// Build option: FFT_BITREV_READ_EN makes rd_addr bit-reverse its low N bits
// so results read back in natural bin order.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N       = 4,
  parameter int FRAMES  = 3,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 1024,
  localparam int L  = 1 << N,
  localparam int D  = FRAMES * L,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  fpt            cfg_data,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          start_ip,
  output fpt            ip,
  output logic          ip_valid,
  input  logic          op_ready,
  input  fpt [1:0]      op_raw,
  input  logic [AW-1:0] rd_addr,
  output fpt            rd_data
);

  // Result buffer holds one beat (two words) per row.
  localparam int RW = AW - 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;   // index of the sample currently on ip
  logic [AW-1:0] k_q, k_d;         // captured beat count
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d, err_q, err_d;
  logic          rd_lsb_q;

  logic          in_re;
  logic [AW-1:0] in_raddr;
  logic          res_we;
  logic [31:0]   res_rdata;
  logic [AW-1:0] rd_map;

  assign busy     = (state_q == S_STREAM) || (state_q == S_GAP) || (state_q == S_DRAIN);
  assign ip_valid = (state_q == S_STREAM);
  // L is a power of two, so the in-frame sample index is just the low N bits.
  assign start_ip = ip_valid && (addr_q[N-1:0] == '0);
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    k_d      = k_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    done_d   = done_q;
    err_d    = err_q;
    in_re    = 1'b0;
    in_raddr = addr_q + 1'b1;
    res_we   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Read sample 0 now so it is on ip the cycle after go.
        if (go) begin
          state_d  = S_STREAM;
          in_re    = 1'b1;
          in_raddr = '0;
          addr_d   = '0;
          k_d      = '0;
          tmo_d    = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_STREAM: begin
        if (&addr_q[N-1:0]) begin
          if (int'(addr_q) == D - 1) begin
            state_d = S_DRAIN;
            tmo_d   = '0;
          end else if (GAP == 0) begin
            in_re  = 1'b1;
            addr_d = addr_q + 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else begin
          in_re  = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      S_GAP: begin
        // Prefetch the next frame head on the last idle cycle; ip holds meanwhile.
        if (int'(gap_q) == GAP - 1) begin
          state_d = S_STREAM;
          in_re   = 1'b1;
          addr_d  = addr_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (int'(k_q) == D / 2) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (int'(tmo_q) == TIMEOUT - 1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Beats past a full buffer are dropped.
    if (busy && op_ready && (int'(k_q) < D / 2)) begin
      res_we = 1'b1;
      k_d    = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      k_q      <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_lsb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_lsb_q <= rd_map[0];
    end
  end

  always_comb begin
    rd_map = rd_addr;
`ifdef FFT_BITREV_READ_EN
    rd_map[N-1:0] = N'(bitrev(32'(rd_addr[N-1:0]), N));
`endif
  end

  fft_seq_ram #(.DW(16), .DEPTH(D), .AW(AW)) u_in_ram (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (cfg_we && !busy),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .re_i    (in_re),
    .raddr_i (in_raddr),
    .rdata_o (ip)
  );

  fft_seq_ram #(.DW(32), .DEPTH(D / 2), .AW(RW)) u_res_ram (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (res_we),
    .waddr_i (k_q[RW-1:0]),
    .wdata_i ({op_raw[1], op_raw[0]}),
    .re_i    (1'b1),
    .raddr_i (rd_map[AW-1:1]),
    .rdata_o (res_rdata)
  );

  assign rd_data = rd_lsb_q ? res_rdata[31:16] : res_rdata[15:0];

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: instance A (FRAMES=1, GAP=0) and instance B
// (FRAMES=3, GAP=2), both N=4 with a short TIMEOUT. The bench plays the fft:
// it scores the ip stream against its own copy of the input buffer and pushes
// every beat it sends onto a result queue that is popped on readback.
module tb_fft_frame_sequencer;
  import fft_pkg::*;

  localparam int TMO = 40;
  localparam int DA  = 16;
  localparam int DB  = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cfg_we_a = 1'b0, cfg_we_b = 1'b0;
  logic       go_a = 1'b0, go_b = 1'b0;
  logic       op_ready_a = 1'b0, op_ready_b = 1'b0;
  logic [5:0] cfg_addr = '0, rd_addr = '0;
  fpt         cfg_data = '0;
  fpt [1:0]   op_raw = '0;

  logic busy_a, done_a, err_a, start_a, valid_a;
  logic busy_b, done_b, err_b, start_b, valid_b;
  fpt   ip_a, rd_a, ip_b, rd_b;

  fft_frame_sequencer #(.N(4), .FRAMES(1), .GAP(0), .TIMEOUT(TMO)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_a), .cfg_addr(cfg_addr[3:0]),
    .cfg_data(cfg_data), .go(go_a), .busy(busy_a), .done(done_a), .err(err_a),
    .start_ip(start_a), .ip(ip_a), .ip_valid(valid_a), .op_ready(op_ready_a),
    .op_raw(op_raw), .rd_addr(rd_addr[3:0]), .rd_data(rd_a)
  );

  fft_frame_sequencer #(.N(4), .FRAMES(3), .GAP(2), .TIMEOUT(TMO)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .go(go_b), .busy(busy_b), .done(done_b), .err(err_b),
    .start_ip(start_b), .ip(ip_b), .ip_valid(valid_b), .op_ready(op_ready_b),
    .op_raw(op_raw), .rd_addr(rd_addr), .rd_data(rd_b)
  );

  int   tests = 0, fails = 0, pat = 1;
  fpt   mem_a [DA];
  fpt   mem_b [DB];
  fpt   last_b [DB];
  fpt   ipq [$];
  fpt   resq [$];
  int   gapq [$];

  // Host index that reads raw result index j.
  function automatic logic [5:0] tb_map(input logic [5:0] j);
    logic [5:0] r;
    r = j;
`ifdef FFT_BITREV_READ_EN
    r[3:0] = {j[0], j[1], j[2], j[3]};
`endif
    return r;
  endfunction

  task automatic load(input bit sel, input bit impulse);
    for (int i = 0; i < (sel ? DB : DA); i++) begin
      fpt v;
      v = impulse ? ((i == 0) ? FPT_ONE : fpt'(0)) : fpt'($urandom);
      if (sel) mem_b[i] = v; else mem_a[i] = v;
      cfg_addr = 6'(i); cfg_data = v; cfg_we_b = sel; cfg_we_a = !sel;
      @(negedge clk);
    end
    cfg_we_a = 1'b0; cfg_we_b = 1'b0;
  endtask

  // One run: go, score ip, send nbeats beats (plus nextra that must be
  // dropped) starting at cycle beat_from, optionally poke go/cfg mid-run.
  task automatic run(input bit sel, input bit impulse, input int beat_from,
                     input int nbeats, input int nextra, input bit poke,
                     output int nval, output int nstart, output int ndrain,
                     output logic [3:0] first);
    int beats, idle, cyc, d;
    fpt e, w0, w1;
    d = sel ? DB : DA;
    nval = 0; nstart = 0; ndrain = 0; beats = 0; idle = 0; cyc = 0;
    gapq.delete();
    for (int i = 0; i < d; i++) ipq.push_back(sel ? mem_b[i] : mem_a[i]);
    if (sel) go_b = 1'b1; else go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0; go_b = 1'b0;
    first = sel ? {done_b, err_b, valid_b, start_b} : {done_a, err_a, valid_a, start_a};
    while (!(sel ? done_b : done_a) && cyc < 2000) begin
      if (sel ? valid_b : valid_a) begin
        if (sel ? start_b : start_a) begin
          nstart++;
          if (nval > 0) gapq.push_back(idle);
        end
        idle = 0; nval++;
        tests++;
        if (ipq.size() == 0) begin
          fails++; $display("FAIL ip_stream: sample %0d beyond expected %0d", nval, d);
        end else begin
          e = ipq.pop_front();
          if ((sel ? ip_b : ip_a) !== e) begin
            fails++;
            $display("FAIL ip_sample: idx %0d got %h exp %h", nval - 1, sel ? ip_b : ip_a, e);
          end
        end
      end else if (sel ? busy_b : busy_a) begin
        idle++;
        if (nval == d) ndrain++;
      end
      op_ready_a = 1'b0; op_ready_b = 1'b0; cfg_we_b = 1'b0; go_b = 1'b0;
      if (cyc >= beat_from && beats < nbeats + nextra) begin
        w0 = impulse ? FPT_ONE : fpt'(pat);
        w1 = impulse ? FPT_ONE : fpt'(pat + 1);
        pat += 2;
        op_raw[0] = w0; op_raw[1] = w1;
        if (sel) op_ready_b = 1'b1; else op_ready_a = 1'b1;
        if (beats < nbeats) begin resq.push_back(w0); resq.push_back(w1); end
        beats++;
      end
      if (poke && (cyc == 5 || cyc == 6)) begin
        go_b = 1'b1; cfg_we_b = 1'b1;
        cfg_addr = (cyc == 5) ? 6'd40 : 6'd5;
        cfg_data = ~mem_b[cfg_addr];
      end
      @(negedge clk);
      cyc++;
    end
    op_ready_a = 1'b0; op_ready_b = 1'b0; cfg_we_b = 1'b0; go_b = 1'b0;
    tests++;
    if (!(sel ? done_b : done_a)) begin
      fails++; $display("FAIL run_bound: done=0 after %0d cycles, required 1", cyc);
    end
    ipq.delete();
  endtask

  task automatic readback(input bit sel);
    fpt e, got;
    for (int j = 0; j < (sel ? DB : DA); j++) begin
      rd_addr = tb_map(6'(j));
      @(negedge clk);
      got = sel ? rd_b : rd_a;
      tests++;
      if (resq.size() == 0) begin
        fails++; $display("FAIL readback: raw %0d has no expected word", j);
      end else begin
        e = resq.pop_front();
        if (sel) last_b[j] = e;
        if (got !== e) begin
          fails++; $display("FAIL readback: raw %0d got %h exp %h", j, got, e);
        end
      end
    end
    tests++;
    if (resq.size() != 0) begin
      fails++; $display("FAIL readback_count: %0d words left over, required 0", resq.size());
    end
    resq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy_a, done_a, err_a, start_a, valid_a, ip_a, rd_a} !== '0) begin
      fails++; $display("FAIL reset_a: outputs %h, required 0",
                        {busy_a, done_a, err_a, start_a, valid_a, ip_a, rd_a});
    end
    tests++;
    if ({busy_b, done_b, err_b, start_b, valid_b, ip_b, rd_b} !== '0) begin
      fails++; $display("FAIL reset_b: outputs %h, required 0",
                        {busy_b, done_b, err_b, start_b, valid_b, ip_b, rd_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    int nv, ns, nd;
    logic [3:0] f;
    load(1'b0, 1'b1);
    run(1'b0, 1'b1, 15, 8, 0, 1'b0, nv, ns, nd, f);
    tests++;
    if (f !== 4'b0011) begin fails++; $display("FAIL impulse_first: {done,err,valid,start}=%b exp 0011", f); end
    tests++;
    if (ns != 1) begin fails++; $display("FAIL impulse_start: got %0d exp 1", ns); end
    tests++;
    if (nv != 16) begin fails++; $display("FAIL impulse_valid: got %0d exp 16", nv); end
    tests++;
    if ({done_a, err_a} !== 2'b10) begin fails++; $display("FAIL impulse_status: {done,err}=%b exp 10", {done_a, err_a}); end
    readback(1'b0);
  endtask

  task automatic test_multiframe();
    int nv, ns, nd;
    logic [3:0] f;
    load(1'b1, 1'b0);
    // 4 surplus beats land while still streaming and must be dropped.
    run(1'b1, 1'b0, 0, 24, 4, 1'b0, nv, ns, nd, f);
    tests++;
    if (ns != 3) begin fails++; $display("FAIL multi_start: got %0d exp 3", ns); end
    tests++;
    if (nv != 48) begin fails++; $display("FAIL multi_valid: got %0d exp 48", nv); end
    tests++;
    if (gapq.size() != 2) begin fails++; $display("FAIL multi_gapcount: got %0d exp 2", gapq.size()); end
    foreach (gapq[i]) begin
      tests++;
      if (gapq[i] != 2) begin fails++; $display("FAIL multi_gap: gap %0d got %0d exp 2", i, gapq[i]); end
    end
    tests++;
    if ({done_b, err_b} !== 2'b10) begin fails++; $display("FAIL multi_status: {done,err}=%b exp 10", {done_b, err_b}); end
    readback(1'b1);
  endtask

  task automatic test_bitrev();
`ifdef FFT_BITREV_READ_EN
    rd_addr = 6'd1;
`else
    rd_addr = 6'd8;
`endif
    @(negedge clk);
    tests++;
    if (rd_b !== last_b[8]) begin fails++; $display("FAIL bitrev_raw8: got %h exp %h", rd_b, last_b[8]); end
`ifdef FFT_BITREV_READ_EN
    rd_addr = 6'd8;
`else
    rd_addr = 6'd1;
`endif
    @(negedge clk);
    tests++;
    if (rd_b !== last_b[1]) begin fails++; $display("FAIL bitrev_raw1: got %h exp %h", rd_b, last_b[1]); end
  endtask

  task automatic test_timeout();
    int nv, ns, nd;
    logic [3:0] f;
    run(1'b0, 1'b0, 0, 0, 0, 1'b0, nv, ns, nd, f);
    tests++;
    if (nv != 16) begin fails++; $display("FAIL timeout_valid: got %0d exp 16", nv); end
    tests++;
    if (nd != TMO) begin fails++; $display("FAIL timeout_cycles: drain got %0d exp %0d", nd, TMO); end
    tests++;
    if ({done_a, err_a} !== 2'b11) begin fails++; $display("FAIL timeout_status: {done,err}=%b exp 11", {done_a, err_a}); end
  endtask

  task automatic test_ignore();
    int nv, ns, nd;
    logic [3:0] f;
    run(1'b1, 1'b0, 0, 24, 0, 1'b1, nv, ns, nd, f);
    tests++;
    if (f[3:2] !== 2'b00) begin fails++; $display("FAIL ignore_clear: {done,err}=%b exp 00", f[3:2]); end
    tests++;
    if (nv != 48 || ns != 3) begin fails++; $display("FAIL ignore_stream: valid %0d start %0d exp 48 3", nv, ns); end
    tests++;
    if ({done_b, err_b} !== 2'b10) begin fails++; $display("FAIL ignore_status: {done,err}=%b exp 10", {done_b, err_b}); end
    readback(1'b1);
  endtask

  task automatic test_back_to_back();
    int nv, ns, nd;
    logic [3:0] f;
    run(1'b0, 1'b1, 15, 8, 0, 1'b0, nv, ns, nd, f);
    tests++;
    if (f !== 4'b0011) begin fails++; $display("FAIL b2b_clear: {done,err,valid,start}=%b exp 0011", f); end
    tests++;
    if ({done_a, err_a} !== 2'b10) begin fails++; $display("FAIL b2b_status_a: {done,err}=%b exp 10", {done_a, err_a}); end
    readback(1'b0);
    run(1'b1, 1'b0, 3, 24, 0, 1'b0, nv, ns, nd, f);
    tests++;
    if (nv != 48) begin fails++; $display("FAIL b2b_valid_b: got %0d exp 48", nv); end
    tests++;
    if ({done_b, err_b} !== 2'b10) begin fails++; $display("FAIL b2b_status_b: {done,err}=%b exp 10", {done_b, err_b}); end
    readback(1'b1);
  endtask

  task automatic test_reset_midrun();
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy_a, done_a, err_a, start_a, valid_a, ip_a} !== '0) begin
      fails++; $display("FAIL midrun_reset: outputs %h, required 0",
                        {busy_a, done_a, err_a, start_a, valid_a, ip_a});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_multiframe();
    test_bitrev();
    test_timeout();
    test_ignore();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
